// File: rtl/ee357_imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// ee357_imm_extend_pipe
//
// Pipelined immediate-extension unit for the multicycle datapath. It widens
// an IN_W-bit immediate to an OUT_W-bit operand in one of four modes:
//   00 zero-extend, 01 sign-extend, 10 upper-load, 11 scaled branch offset.
// The result passes through two register stages, with a valid/ready
// handshake on both sides. A wrapping counter records completed output
// transfers for debug and performance monitoring.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_data/in_mode valid this cycle
//   in_ready   block accepts input this cycle
//   in_data    raw immediate, IN_W bits
//   in_mode    extension mode, 2 bits
//   out_valid  out_data valid
//   out_ready  consumer accepts out_data this cycle
//   out_data   extended result, OUT_W bits
//   xfer_count completed output transfers, mod 2^CNT_W
// ---------------------------------------------------------------------------
module ee357_imm_extend_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] xfer_count
);

  // Number of bits added on top of the immediate.
  localparam int M = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  // Stage 1: raw immediate and mode.
  logic             v1_q, v1_d;
  logic [IN_W-1:0]  d1_q, d1_d;
  mode_e            m1_q, m1_d;

  // Stage 2: extended result.
  logic             v2_q, v2_d;
  logic [OUT_W-1:0] d2_q, d2_d;

  // Completed-transfer counter.
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Handshake terms.
  logic adv1;
  logic adv2;
  logic accept;
  logic xfer;

  // -------------------------------------------------------------------------
  // Extension arithmetic
  // -------------------------------------------------------------------------
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] x,
                                              input mode_e           mode);
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] res;
    sext = {{M{x[IN_W-1]}}, x};
    unique case (mode)
      MODE_ZERO:   res = {{M{1'b0}}, x};
      // {x, M zeros} is exactly OUT_W wide, so x lands at [OUT_W-1:M].
      MODE_UPPER:  res = {x, {M{1'b0}}};
      // Bits pushed past the MSB are dropped by the fixed result width.
      MODE_BRANCH: res = sext << BR_SHIFT;
      default:     res = sext;
    endcase
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  // Each stage may take new data when it is empty or when its contents move
  // on this edge. in_ready therefore depends only on state and out_ready,
  // never on in_valid.
  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && adv1;
  assign xfer     = v2_q && out_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal gets a hold-value default before any condition, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    v1_d  = v1_q;
    d1_d  = d1_q;
    m1_d  = m1_q;
    v2_d  = v2_q;
    d2_d  = d2_q;
    cnt_d = cnt_q;

    // Stage 1 reloads whenever it can advance; an empty load is a bubble.
    if (adv1) begin
      v1_d = accept;
      if (accept) begin
        d1_d = in_data;
        m1_d = mode_e'(in_mode);
      end
    end

    // Stage 2 takes whatever stage 1 holds. When stage 1 is empty the data
    // register keeps its old value; only the valid flag clears.
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        d2_d = extend(d1_q, m1_q);
      end
    end

    // Natural wrap at 2^CNT_W.
    if (xfer) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before this edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data registers are cleared as well as the valid flags, so
      // out_data reads zero after reset and held values are discarded.
      v1_q  <= 1'b0;
      d1_q  <= '0;
      m1_q  <= MODE_ZERO;
      v2_q  <= 1'b0;
      d2_q  <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      d1_q  <= d1_d;
      m1_q  <= m1_d;
      v2_q  <= v2_d;
      d2_q  <= d2_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = v2_q;
  assign out_data   = d2_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_ee357_imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// tb_ee357_imm_extend_pipe
//
// Self-checking bench for ee357_imm_extend_pipe (16 -> 32, branch shift 2).
// A second instance with a 4-bit counter shares the stimulus so that the
// counter wrap can be reached in a few dozen transfers.
// ---------------------------------------------------------------------------
module tb_ee357_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] xfer_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_data;
  logic [3:0]  s_xfer_count;

  int checks   = 0;
  int failures = 0;

  ee357_imm_extend_pipe #(
    .IN_W(16), .OUT_W(32), .BR_SHIFT(2), .CNT_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .xfer_count (xfer_count)
  );

  ee357_imm_extend_pipe #(
    .IN_W(16), .OUT_W(32), .BR_SHIFT(2), .CNT_W(4)
  ) dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .out_data   (s_out_data),
    .xfer_count (s_xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one value through an otherwise idle pipe and let it transfer.
  task automatic xfer_one(input logic [1:0] mode, input logic [15:0] data);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    step();
    in_valid = 1'b0;
    step();
    step();
  endtask

  int          sent;
  int          popped;
  int          occ;
  int          base;
  logic        stall_prev;
  logic [31:0] held;
  logic        do_pop;
  logic        do_push;

  initial begin
    vecs[0] = '{2'b01, 16'h8001, 32'hffff8001};
    vecs[1] = '{2'b01, 16'h0003, 32'h00000003};
    vecs[2] = '{2'b00, 16'h8001, 32'h00008001};
    vecs[3] = '{2'b10, 16'h1234, 32'h12340000};
    vecs[4] = '{2'b10, 16'hffff, 32'hffff0000};
    vecs[5] = '{2'b11, 16'hffff, 32'hfffffffc};
    vecs[6] = '{2'b11, 16'h0003, 32'h0000000c};
    vecs[7] = '{2'b11, 16'h8000, 32'hfffe0000};
    vecs[8] = '{2'b01, 16'h7fff, 32'h00007fff};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_count", {16'b0, xfer_count}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed vectors, one at a time: latency and function per mode.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_mode  = vecs[i].mode;
      in_data  = vecs[i].data;
      #1;
      check($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_not_yet", i), {31'b0, out_valid}, 32'd0);
      step();
      check($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("v%0d_data", i), out_data, vecs[i].exp);
      step();
      check($sformatf("v%0d_drained", i), {31'b0, out_valid}, 32'd0);
      check($sformatf("v%0d_count", i), {16'b0, xfer_count}, i + 1);
    end

    // Back-to-back stream of 8 with out_ready low in cycles 3..5.
    base       = 9;
    sent       = 0;
    popped     = 0;
    occ        = 0;
    stall_prev = 1'b0;
    held       = '0;
    for (int cyc = 0; cyc < 60 && popped < 8; cyc++) begin
      in_valid  = (sent < 8);
      in_mode   = vecs[sent < 8 ? sent : 0].mode;
      in_data   = vecs[sent < 8 ? sent : 0].data;
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      check($sformatf("s%0d_in_ready", cyc), {31'b0, in_ready},
            {31'b0, !(occ == 2 && !out_ready)});
      if (stall_prev) begin
        check($sformatf("s%0d_hold_valid", cyc), {31'b0, out_valid}, 32'd1);
        check($sformatf("s%0d_hold_data", cyc), out_data, held);
      end
      do_pop  = out_valid && out_ready;
      do_push = in_valid && in_ready;
      if (do_pop) begin
        check($sformatf("s_out%0d", popped), out_data, vecs[popped].exp);
        popped++;
      end
      if (do_push) sent++;
      occ        = occ + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      stall_prev = out_valid && !out_ready;
      held       = out_data;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_all_out", popped, 32'd8);
    check("stream_count", {16'b0, xfer_count}, base + 8);

    // Fill both stages with out_ready low, then reset mid-transfer.
    out_ready = 1'b0;
    in_mode   = 2'b00;
    in_data   = 16'habcd;
    in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!in_ready) break;
      step();
    end
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_out_valid", {31'b0, out_valid}, 32'd1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_count", {16'b0, xfer_count}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_out_data", out_data, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("mid_rst_no_emit%0d", k), {31'b0, out_valid}, 32'd0);
    end
    check("mid_rst_count_hold", {16'b0, xfer_count}, 32'd0);

    // Counter wrap on the 4-bit instance; the 16-bit one keeps counting.
    for (int k = 0; k < 15; k++) xfer_one(2'b01, 16'(k));
    check("wrap_pre_small", {28'b0, s_xfer_count}, 32'd15);
    xfer_one(2'b11, 16'h0001);
    check("wrap_small", {28'b0, s_xfer_count}, 32'd0);
    check("wrap_main", {16'b0, xfer_count}, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ee357_imm_extend_pipe.md
Name: ee357_imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the multicycle datapath; successor to the fixed 16-to-32 sign extender.
- Takes an IN_W-bit immediate plus a 2-bit mode and produces an OUT_W-bit operand:
  - zero-extend
  - sign-extend
  - upper-load
  - scaled branch offset
- Two-stage registered pipeline with valid/ready handshake on both sides, plus a wrapping completed-transfer counter for debug/perf.

Parameters:
- IN_W, 16, immediate input width; must be >= 2 and < OUT_W.
- OUT_W, 32, extended output width.
- BR_SHIFT, 2, left-shift amount for branch mode; 0 <= BR_SHIFT < OUT_W.
- CNT_W, 16, width of transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_data/in_mode valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  IN_W  raw immediate.
- in_mode  input  2  00 zero, 01 sign, 10 upper, 11 branch.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  OUT_W  extended result.
- xfer_count  output  CNT_W  number of completed output transfers, mod 2^CNT_W.

Behaviour:
- Reset: clk edge with rst_n=0 clears both stage-valid flags and xfer_count.
  - After reset: out_valid=0, out_data=0, xfer_count=0, in_ready=1.
  - Stage data registers reset to 0.
  - Reset has priority over every other event, including mid-transfer. In-flight data is discarded, not emitted.
- Stage 1 (S1) registers in_data and in_mode. Stage 2 (S2) registers the computed result; out_valid = S2 valid, out_data = S2 data.
- Handshake:
  - adv2 = !v2 || out_ready
  - adv1 = !v1 || adv2
  - in_ready = adv1 (combinational; no combinational path from in_valid to in_ready)
  - Input accepted when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: an input accepted at edge N appears on out_data/out_valid after edge N+1, i.e. 2 edges from accept to visible output with the pipe not stalled. Throughput is 1 per cycle with out_ready held high.
- Stall: when out_valid=1 and out_ready=0, out_data and out_valid hold stable. S1 holds if full. in_ready drops only when both stages are full and out_ready=0. No loss, no duplication.
- Bubbles: when S1 is empty and adv2 is true, S2 loads invalid (v2 <= 0). out_data may retain its old value when out_valid=0; bench must not check it then.
- Arithmetic, with x = in_data and M = OUT_W - IN_W:
  - 00: {M zeros, x}.
  - 01: {M copies of x[IN_W-1], x}.
  - 10: x placed at out[OUT_W-1 : M], low M bits zero. If M < IN_W, only the low IN_W-M... no truncation: the top OUT_W bits of {x, M zeros} are used (for 16/32: x<<16).
  - 11: sign-extend as 01, then shift left BR_SHIFT. Bits shifted past bit OUT_W-1 are discarded; low BR_SHIFT bits are zero.
- Counter: xfer_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0. No increment during reset.
- Simultaneous events: an accept into S1, advance S1->S2 and output transfer can all occur on the same edge. All must take effect, with the count incremented exactly once.
- Undefined inputs are not required to be handled; all 4 mode codes are legal.

Test Plan (IN_W=16, OUT_W=32, BR_SHIFT=2, CNT_W=16):
- mode 01, in 16'h8001 then 16'h0003, out_ready=1 -> out 32'hffff8001 then 32'h00000003, each 2 edges after accept; xfer_count=2.
- mode 00 16'h8001 -> 32'h00008001; mode 10 16'h1234 -> 32'h12340000; mode 10 16'hffff -> 32'hffff0000.
- mode 11 16'hffff -> 32'hfffffffc; 16'h0003 -> 32'h0000000c; 16'h8000 -> 32'hfffe0000.
- Back-to-back stream of 8 values with out_ready low for cycles 3-5 -> out_data held stable while stalled, in_ready low only while S1 and S2 are both full, all 8 results emitted in order, xfer_count=8.
- Pipe full (in_ready=0) and out_ready=0, pulse rst_n low 1 edge -> next cycle out_valid=0, xfer_count=0, in_ready=1; the held values never appear on output.
- Preset 65535 transfers (or a CNT_W=4 build with 16 transfers) -> xfer_count wraps to 0 on the next transfer.
